// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - reads one 512-byte SD sector over the byte-level sd SPI unit
// Issues CMD17, polls R1 and the start token, then streams the payload into the sector buffer.
module sd_block_reader #(
  parameter int SDHC        = 1,
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we
);

  typedef enum logic [3:0] {
    S_IDLE, S_CSL, S_SYNC, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC,
    S_CS_HI, S_CS_REL, S_FIN, S_OP_REQ, S_OP_WHI, S_OP_WLO
  } state_t;

  localparam logic [12:0] R1_LAST  = 13'(R1_TRIES - 1);
  localparam logic [12:0] TOK_LAST = 13'(TOKEN_TRIES - 1);

  localparam logic [2:0] E_R1_TIMEOUT  = 3'd1;
  localparam logic [2:0] E_R1_BAD      = 3'd2;
  localparam logic [2:0] E_TOK_TIMEOUT = 3'd3;
  localparam logic [2:0] E_TOK_BAD     = 3'd4;
  localparam logic [2:0] E_SD_TIMEOUT  = 3'd5;

  state_t      state;
  state_t      ret_state;
  logic        got;
  logic [7:0]  rx;
  logic [31:0] addr;
  logic [2:0]  idx;
  logic [8:0]  cnt;
  logic [12:0] poll;

  logic [31:0] addr_next;
  logic [1:0]  issue_cmd;
  logic [7:0]  issue_byte;

  assign addr_next = (SDHC != 0) ? lba : {lba[22:0], 9'd0};

  // Command and byte that the current main state hands to the sd unit.
  always_comb begin
    issue_cmd  = 2'd1;
    issue_byte = 8'hFF;
    case (state)
      S_CSL:   issue_cmd = 2'd2;
      S_CS_HI: issue_cmd = 2'd3;
      S_CMD: begin
        case (idx)
          3'd0:    issue_byte = 8'h51;
          3'd1:    issue_byte = addr[31:24];
          3'd2:    issue_byte = addr[23:16];
          3'd3:    issue_byte = addr[15:8];
          3'd4:    issue_byte = addr[7:0];
          default: issue_byte = 8'hFF;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      got       <= 1'b0;
      rx        <= 8'h00;
      addr      <= 32'd0;
      idx       <= 3'd0;
      cnt       <= 9'd0;
      poll      <= 13'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 3'd0;
      sd_signal <= 1'b0;
      sd_cmd    <= 2'd0;
      sd_out    <= 8'hFF;
      buf_addr  <= 9'd0;
      buf_data  <= 8'h00;
      buf_we    <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr     <= addr_next;
            error    <= 1'b0;
            err_code <= 3'd0;
            busy     <= 1'b1;
            got      <= 1'b0;
            state    <= S_CSL;
          end
        end

        S_OP_REQ, S_OP_WHI, S_OP_WLO: begin
          sd_signal <= 1'b0;
          if (sd_timeout) begin
            err_code <= E_SD_TIMEOUT;
            got      <= 1'b0;
            // A timeout while already releasing CS must not loop back into CS_HI.
            if (ret_state == S_CS_HI || ret_state == S_CS_REL) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              error <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_CS_HI;
            end
          end else if (state == S_OP_REQ) begin
            state <= S_OP_WHI;
          end else if (state == S_OP_WHI) begin
            if (sd_busy) state <= S_OP_WLO;
          end else if (!sd_busy) begin
            rx    <= sd_din;
            got   <= 1'b1;
            state <= ret_state;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          if (!got) begin
            sd_cmd    <= issue_cmd;
            sd_out    <= issue_byte;
            sd_signal <= 1'b1;
            ret_state <= state;
            state     <= S_OP_REQ;
          end else begin
            got <= 1'b0;
            case (state)
              S_CSL:  state <= S_SYNC;
              S_SYNC: begin
                idx   <= 3'd0;
                state <= S_CMD;
              end
              S_CMD: begin
                if (idx == 3'd5) begin
                  poll  <= 13'd0;
                  state <= S_R1;
                end else begin
                  idx <= idx + 3'd1;
                end
              end
              S_R1: begin
                if (rx == 8'hFF) begin
                  if (poll == R1_LAST) begin
                    err_code <= E_R1_TIMEOUT;
                    state    <= S_CS_HI;
                  end else begin
                    poll <= poll + 13'd1;
                  end
                end else if (rx == 8'h00) begin
                  poll  <= 13'd0;
                  state <= S_TOKEN;
                end else begin
                  err_code <= E_R1_BAD;
                  state    <= S_CS_HI;
                end
              end
              S_TOKEN: begin
                if (rx == 8'hFE) begin
                  cnt   <= 9'd0;
                  state <= S_DATA;
                end else if (rx == 8'hFF) begin
                  if (poll == TOK_LAST) begin
                    err_code <= E_TOK_TIMEOUT;
                    state    <= S_CS_HI;
                  end else begin
                    poll <= poll + 13'd1;
                  end
                end else begin
                  err_code <= E_TOK_BAD;
                  state    <= S_CS_HI;
                end
              end
              S_DATA: begin
                buf_we   <= 1'b1;
                buf_data <= rx;
                buf_addr <= cnt;
                cnt      <= cnt + 9'd1;
                if (cnt == 9'h1FF) begin
                  idx   <= 3'd0;
                  state <= S_CRC;
                end
              end
              S_CRC: begin
                if (idx == 3'd1) state <= S_CS_HI;
                else             idx <= idx + 3'd1;
              end
              S_CS_HI: state <= S_CS_REL;
              S_CS_REL: begin
                done  <= 1'b1;
                busy  <= 1'b0;
                error <= (err_code != 3'd0);
                state <= S_FIN;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// tb/tb_sd_block_reader.sv - directed vector bench for sd_block_reader with a behavioural sd/card model
module tb_sd_block_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] lba = 32'd0;
  logic        sel = 1'b1;
  logic [7:0]  sd_din = 8'hFF;
  logic        sd_busy = 1'b0;
  logic        sd_timeout = 1'b0;

  logic        u1_busy, u1_done, u1_error, u1_sig, u1_we;
  logic [2:0]  u1_code;
  logic [1:0]  u1_cmd;
  logic [7:0]  u1_out, u1_data;
  logic [8:0]  u1_addr;
  logic        u0_busy, u0_done, u0_error, u0_sig, u0_we;
  logic [2:0]  u0_code;
  logic [1:0]  u0_cmd;
  logic [7:0]  u0_out, u0_data;
  logic [8:0]  u0_addr;

  logic        start1, start0;
  assign start1 = start & sel;
  assign start0 = start & ~sel;

  sd_block_reader #(.SDHC(1), .R1_TRIES(8), .TOKEN_TRIES(16)) u_hc1 (
    .clock(clock), .reset(reset), .start(start1), .lba(lba),
    .busy(u1_busy), .done(u1_done), .error(u1_error), .err_code(u1_code),
    .sd_signal(u1_sig), .sd_cmd(u1_cmd), .sd_out(u1_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout),
    .buf_addr(u1_addr), .buf_data(u1_data), .buf_we(u1_we)
  );

  sd_block_reader #(.SDHC(0), .R1_TRIES(8), .TOKEN_TRIES(16)) u_hc0 (
    .clock(clock), .reset(reset), .start(start0), .lba(lba),
    .busy(u0_busy), .done(u0_done), .error(u0_error), .err_code(u0_code),
    .sd_signal(u0_sig), .sd_cmd(u0_cmd), .sd_out(u0_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout),
    .buf_addr(u0_addr), .buf_data(u0_data), .buf_we(u0_we)
  );

  logic        d_busy, d_done, d_error, d_sig, d_we;
  logic [2:0]  d_code;
  logic [1:0]  d_cmd;
  logic [7:0]  d_out, d_data;
  logic [8:0]  d_addr;
  assign d_busy  = sel ? u1_busy  : u0_busy;
  assign d_done  = sel ? u1_done  : u0_done;
  assign d_error = sel ? u1_error : u0_error;
  assign d_code  = sel ? u1_code  : u0_code;
  assign d_sig   = sel ? u1_sig   : u0_sig;
  assign d_cmd   = sel ? u1_cmd   : u0_cmd;
  assign d_out   = sel ? u1_out   : u0_out;
  assign d_we    = sel ? u1_we    : u0_we;
  assign d_addr  = sel ? u1_addr  : u0_addr;
  assign d_data  = sel ? u1_data  : u0_data;

  always #5 clock = ~clock;

  logic [7:0] cfg_r1 = 8'h00;
  int         cfg_r1_wait = 0;
  int         cfg_tok_wait = 2;
  bit         cfg_tok_never = 1'b0;
  logic [7:0] cfg_tok = 8'hFE;
  int         cfg_to = -1;

  int          m_cnt = 0;
  logic [7:0]  m_resp = 8'hFF;
  bit          m_to = 1'b0;
  int          xfer = 0;
  bit          cs_hi = 1'b0;
  int          cs_low_cnt = 0;
  int          cshi_cnt = 0;
  int          pre_cshi = -1;
  int          post_cs = 0;
  int          done_cnt = 0;
  bit          done_busy = 1'b0;
  bit          done_cshi = 1'b0;
  int          we_cnt = 0;
  int          last_addr = -1;
  logic [47:0] cmd_log = 48'd0;
  logic [7:0]  mem [512];

  function automatic logic [7:0] card_resp(int k);
    int k1, t, d;
    k1 = 7 + cfg_r1_wait;
    if (k < k1) return 8'hFF;
    if (k == k1) return cfg_r1;
    if (cfg_r1 != 8'h00 || cfg_tok_never) return 8'hFF;
    t = k - k1 - 1;
    if (t < cfg_tok_wait) return 8'hFF;
    if (t == cfg_tok_wait) return cfg_tok;
    d = t - cfg_tok_wait - 1;
    if (d < 512) return d[7:0] ^ 8'h5A;
    return 8'hFF;
  endfunction

  function automatic int data_idx(int k);
    int k1, t;
    k1 = 7 + cfg_r1_wait;
    if (k <= k1 || cfg_r1 != 8'h00 || cfg_tok_never) return -1;
    t = k - k1 - 1;
    if (t <= cfg_tok_wait) return -1;
    return t - cfg_tok_wait - 1;
  endfunction

  // sd unit + card model, and buffer/done monitor, all on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      sd_busy    = 1'b0;
      sd_timeout = 1'b0;
      m_cnt      = 0;
    end else begin
      sd_timeout = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          sd_busy = 1'b0;
          if (m_to) sd_timeout = 1'b1;
          else      sd_din = m_resp;
        end
      end else if (d_sig) begin
        sd_busy = 1'b1;
        m_cnt   = 2;
        m_to    = 1'b0;
        m_resp  = 8'hFF;
        case (d_cmd)
          2'd2: begin
            cs_low_cnt = cs_low_cnt + 1;
            xfer = 0; cs_hi = 1'b0; cshi_cnt = 0; pre_cshi = -1; post_cs = 0;
            done_cnt = 0; we_cnt = 0; last_addr = -1; cmd_log = 48'd0;
            for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
          end
          2'd3: begin
            cshi_cnt = cshi_cnt + 1;
            cs_hi    = 1'b1;
            pre_cshi = xfer;
          end
          2'd1: begin
            if (cs_hi) begin
              post_cs = post_cs + 1;
            end else begin
              if (xfer >= 1 && xfer <= 6) cmd_log = {cmd_log[39:0], d_out};
              m_resp = card_resp(xfer);
              m_to   = (cfg_to >= 0) && (data_idx(xfer) == cfg_to);
            end
            xfer = xfer + 1;
          end
          default: ;
        endcase
      end
    end
    if (d_we) begin
      mem[d_addr] = d_data;
      we_cnt      = we_cnt + 1;
      last_addr   = int'(d_addr);
    end
    if (d_done) begin
      done_cnt  = done_cnt + 1;
      done_busy = d_busy;
      done_cshi = (cshi_cnt > 0);
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit          hc;
    logic [31:0] lba;
    logic [7:0]  r1;
    int          r1_wait;
    int          tok_wait;
    bit          tok_never;
    logic [7:0]  tok;
    int          to;
    logic [2:0]  exp_code;
    int          exp_writes;
    logic [47:0] exp_cmd;
    int          exp_pre;
  } vec_t;

  vec_t v [11];

  task automatic run_vec(input vec_t x, input int id);
    bit got;
    int cl0, bad;
    sel = x.hc;
    cfg_r1 = x.r1; cfg_r1_wait = x.r1_wait; cfg_tok_wait = x.tok_wait;
    cfg_tok_never = x.tok_never; cfg_tok = x.tok; cfg_to = x.to;
    cl0 = cs_low_cnt;
    @(negedge clock);
    lba = x.lba;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", id), d_busy, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      @(negedge clock);
      if (d_done) begin got = 1'b1; break; end
    end
    chk($sformatf("v%0d done_seen", id), got, 1'b1);
    repeat (3) @(negedge clock);
    bad = 0;
    for (int a = 0; a < x.exp_writes; a++)
      if (mem[a] !== (8'(a) ^ 8'h5A)) bad = bad + 1;
    chk($sformatf("v%0d err_code", id), d_code, x.exp_code);
    chk($sformatf("v%0d error", id), d_error, (x.exp_code != 3'd0));
    chk($sformatf("v%0d done_pulses", id), done_cnt, 1);
    chk($sformatf("v%0d busy_at_done", id), done_busy, 1'b0);
    chk($sformatf("v%0d cs_hi_before_done", id), done_cshi, 1'b1);
    chk($sformatf("v%0d cs_low_ops", id), cs_low_cnt - cl0, 1);
    chk($sformatf("v%0d cmd_bytes", id), cmd_log, x.exp_cmd);
    chk($sformatf("v%0d xfers_before_cs_hi", id), pre_cshi, x.exp_pre);
    chk($sformatf("v%0d release_xfers", id), post_cs, 1);
    chk($sformatf("v%0d buf_writes", id), we_cnt, x.exp_writes);
    chk($sformatf("v%0d bad_bytes", id), bad, 0);
    if (x.exp_writes > 0)
      chk($sformatf("v%0d last_addr", id), last_addr, x.exp_writes - 1);
    chk($sformatf("v%0d busy_idle", id), d_busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hit;
    v[0]  = '{1'b1, 32'h00001234, 8'h00, 0, 2,  1'b0, 8'hFE, -1,  3'd0, 512, 48'h5100001234FF, 525};
    v[1]  = '{1'b0, 32'h00000003, 8'h00, 0, 2,  1'b0, 8'hFE, -1,  3'd0, 512, 48'h5100000600FF, 525};
    v[2]  = '{1'b1, 32'hA5A5A5A5, 8'h05, 0, 2,  1'b0, 8'hFE, -1,  3'd2, 0,   48'h51A5A5A5A5FF, 8};
    v[3]  = '{1'b1, 32'h00001234, 8'h00, 0, 0,  1'b1, 8'hFE, -1,  3'd3, 0,   48'h5100001234FF, 24};
    v[4]  = '{1'b1, 32'h00001234, 8'h00, 0, 2,  1'b0, 8'hFE, 100, 3'd5, 100, 48'h5100001234FF, 112};
    v[5]  = '{1'b1, 32'h00001234, 8'h00, 8, 2,  1'b0, 8'hFE, -1,  3'd1, 0,   48'h5100001234FF, 15};
    v[6]  = '{1'b1, 32'h00001234, 8'h00, 0, 2,  1'b0, 8'hFC, -1,  3'd4, 0,   48'h5100001234FF, 11};
    v[7]  = '{1'b0, 32'h00800001, 8'h00, 0, 2,  1'b0, 8'hFE, -1,  3'd0, 512, 48'h5100000200FF, 525};
    v[8]  = '{1'b1, 32'hFFFFFFFF, 8'h00, 3, 0,  1'b0, 8'hFE, -1,  3'd0, 512, 48'h51FFFFFFFFFF, 526};
    v[9]  = '{1'b1, 32'h00001234, 8'h00, 0, 15, 1'b0, 8'hFE, -1,  3'd0, 512, 48'h5100001234FF, 538};
    v[10] = '{1'b1, 32'h00001234, 8'h00, 7, 2,  1'b0, 8'hFE, -1,  3'd0, 512, 48'h5100001234FF, 532};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst busy", u1_busy, 1'b0);
    chk("rst done", u1_done, 1'b0);
    chk("rst error", u1_error, 1'b0);
    chk("rst err_code", u1_code, 3'd0);
    chk("rst sd_signal", u1_sig, 1'b0);
    chk("rst sd_cmd", u1_cmd, 2'd0);
    chk("rst sd_out", u1_out, 8'hFF);
    chk("rst buf_we", u1_we, 1'b0);
    chk("rst buf_addr", u1_addr, 9'd0);
    chk("rst hc0 sd_out", u0_out, 8'hFF);

    for (int i = 0; i < 11; i++) run_vec(v[i], i);

    // start while busy is ignored, then reset mid-data
    sel = 1'b1;
    cfg_r1 = 8'h00; cfg_r1_wait = 0; cfg_tok_wait = 2; cfg_tok_never = 1'b0; cfg_tok = 8'hFE; cfg_to = -1;
    @(negedge clock);
    lba = 32'h00001234;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clock);
      if (u1_we && u1_addr == 9'd200) begin hit = 1'b1; break; end
    end
    chk("seq reach_byte200", hit, 1'b1);
    lba = 32'h0000DEAD;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clock);
      if (u1_we && u1_addr == 9'd300) begin hit = 1'b1; break; end
    end
    chk("seq reach_byte300", hit, 1'b1);
    chk("seq no_restart_cs_low", cshi_cnt, 0);
    chk("seq cmd_bytes_kept", cmd_log, 48'h5100001234FF);
    reset = 1'b1;
    #1;
    chk("seq rst busy", u1_busy, 1'b0);
    chk("seq rst sd_signal", u1_sig, 1'b0);
    chk("seq rst buf_we", u1_we, 1'b0);
    chk("seq rst sd_out", u1_out, 8'hFF);
    chk("seq rst sd_cmd", u1_cmd, 2'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_vec(v[0], 11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
